count_seq_checker: RTL and testbench

//  Downstream monitor for the JK ripple/sync counter stage: samples its count bus every enabled cycle.

---
 rtl/count_seq_checker.sv | 147 ++++++++++++++
 tb/tb_count_seq_checker.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence monitor for a mod-(MAX_VAL+1) counter bus: locks on, flags bad steps, tallies wraps/errors.
// Optional sticky error flag enabled by defining SEQ_CHK_STICKY_ERR_EN.
module count_seq_checker #(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 7,
  parameter int LOCK_N  = 2,
  parameter int CNTW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_q,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             seq_err,
  output logic [CNTW-1:0]  err_cnt,
  output logic [CNTW-1:0]  wrap_cnt,
`ifdef SEQ_CHK_STICKY_ERR_EN
  output logic             err_sticky,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LOCK_W = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [3:0]       lock_q, lock_d;
  logic [WIDTH-1:0] smp_q, smp_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  err_cnt_q, err_cnt_d;
  logic [CNTW-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic             sticky_q, sticky_d;

  logic in_range, at_max, legal, hold;

  // Out-of-range samples are never legal and never count as a hold.
  always_comb begin
    in_range = (cnt_in <= MAX_W);
    at_max   = (smp_q == MAX_W);
    legal    = in_range && (at_max ? (cnt_in == '0) : (cnt_in == smp_q + 1'b1));
    hold     = in_range && (cnt_in == smp_q);
  end

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    smp_d      = smp_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    sticky_d   = sticky_q;

    if (clr) begin
      state_d    = ST_IDLE;
      lock_d     = '0;
      smp_d      = '0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
      sticky_d   = 1'b0;
    end else if (en) begin
      smp_d = cnt_in;
      case (state_q)
        ST_SYNC: begin
          if (legal) begin
            if (lock_q + 4'd1 == LOCK_W) begin
              state_d = ST_LOCKED;
              lock_d  = '0;
            end else begin
              lock_d = lock_q + 4'd1;
            end
          end else if (!hold) begin
            lock_d = '0;
          end
        end
        ST_LOCKED: begin
          if (legal) begin
            if (at_max) begin
              wrap_d = 1'b1;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
          end else if (!hold) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = ST_SYNC;
            lock_d   = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE, and the unused encoding behaves as IDLE.
          if (in_range) begin
            state_d = ST_SYNC;
            lock_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_q     <= '0;
      smp_q      <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      smp_q      <= smp_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cnt_q      = smp_q;
  assign locked     = (state_q == ST_LOCKED);
  assign wrap_pulse = wrap_q;
  assign seq_err    = err_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign state_o    = state_q;
`ifdef SEQ_CHK_STICKY_ERR_EN
  assign err_sticky = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker (WIDTH=3, MAX_VAL=7, LOCK_N=2, CNTW=2 so tallies saturate at 3).
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt_in = 3'd0;
  logic [2:0] cnt_q;
  logic       locked, wrap_pulse, seq_err;
  logic [1:0] err_cnt, wrap_cnt;
  logic [1:0] state_o;
`ifdef SEQ_CHK_STICKY_ERR_EN
  logic       err_sticky;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  count_seq_checker #(.WIDTH(3), .MAX_VAL(7), .LOCK_N(2), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt_in(cnt_in),
    .cnt_q(cnt_q), .locked(locked), .wrap_pulse(wrap_pulse), .seq_err(seq_err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
`ifdef SEQ_CHK_STICKY_ERR_EN
    .err_sticky(err_sticky),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [2:0] v);
    en = e; clr = c; cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic lk,
                         input logic wp, input logic se, input logic [2:0] cq);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(wp));
    chk({tag, ".err"}, 32'(seq_err), 32'(se));
    chk({tag, ".cnt_q"}, 32'(cnt_q), 32'(cq));
  endtask

  initial begin
    #2;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset.err_cnt", 32'(err_cnt), 0);
    chk("reset.wrap_cnt", 32'(wrap_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: acquire lock on 0,1,2
    step(1, 0, 3'd0); chk_all("t1.s0", 2'b01, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1, 0, 3'd1); chk_all("t1.s1", 2'b01, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1, 0, 3'd2); chk_all("t1.s2", 2'b10, 1'b1, 1'b0, 1'b0, 3'd2);

    // 2: wrap 7->0 pulses once
    for (int v = 3; v <= 7; v++) begin
      step(1, 0, 3'(v)); chk_all("t2.up", 2'b10, 1'b1, 1'b0, 1'b0, 3'(v));
    end
    step(1, 0, 3'd0); chk_all("t2.wrap", 2'b10, 1'b1, 1'b1, 1'b0, 3'd0);
    chk("t2.wrap_cnt", 32'(wrap_cnt), 1);
    step(1, 0, 3'd1); chk_all("t2.after", 2'b10, 1'b1, 1'b0, 1'b0, 3'd1);

    // 3: skip 3->5 is an error, then relock on 6,7
    step(1, 0, 3'd2); step(1, 0, 3'd3);
    step(1, 0, 3'd5); chk_all("t3.err", 2'b01, 1'b0, 1'b0, 1'b1, 3'd5);
    chk("t3.err_cnt", 32'(err_cnt), 1);
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("t3.sticky", 32'(err_sticky), 1);
`endif
    step(1, 0, 3'd6); chk_all("t3.s6", 2'b01, 1'b0, 1'b0, 1'b0, 3'd6);
    step(1, 0, 3'd7); chk_all("t3.s7", 2'b10, 1'b1, 1'b0, 1'b0, 3'd7);
    chk("t3.err_cnt_hold", 32'(err_cnt), 1);

    // 4: holds and disabled cycles keep lock without pulses
    step(1, 0, 3'd0); chk("t4.wrap2", 32'(wrap_cnt), 2);
    for (int v = 1; v <= 4; v++) step(1, 0, 3'(v));
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 3'd4); chk_all("t4.hold", 2'b10, 1'b1, 1'b0, 1'b0, 3'd4);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd1); chk_all("t4.dis", 2'b10, 1'b1, 1'b0, 1'b0, 3'd4);
    end
    step(1, 0, 3'd5); chk_all("t4.s5", 2'b10, 1'b1, 1'b0, 1'b0, 3'd5);

    // 5: error tally saturates at 3 (illegal 5->0 then three relock+error rounds)
    step(1, 0, 3'd0); chk_all("t5.e2", 2'b01, 1'b0, 1'b0, 1'b1, 3'd0);
    chk("t5.err_cnt2", 32'(err_cnt), 2);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 3'd1);
      step(1, 0, 3'd2); chk("t5.relock", 32'(locked), 1);
      step(1, 0, 3'd0); chk("t5.seq_err", 32'(seq_err), 1);
      chk("t5.err_sat", 32'(err_cnt), 3);
    end
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("t5.sticky_kept", 32'(err_sticky), 1);
`endif
    step(1, 1, 3'd3); chk_all("t5.clr", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t5.clr_err", 32'(err_cnt), 0);
    chk("t5.clr_wrap", 32'(wrap_cnt), 0);
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("t5.clr_sticky", 32'(err_sticky), 0);
`endif

    // wrap tally saturates at 3
    step(1, 0, 3'd0); step(1, 0, 3'd1); step(1, 0, 3'd2);
    chk("t5.lock_w", 32'(locked), 1);
    for (int k = 0; k < 4; k++) begin
      for (int v = 3; v <= 7; v++) step(1, 0, 3'(v));
      step(1, 0, 3'd0); chk("t5.wp", 32'(wrap_pulse), 1);
      chk("t5.wrap_sat", 32'(wrap_cnt), (k < 3) ? k + 1 : 3);
      step(1, 0, 3'd1); step(1, 0, 3'd2);
    end

    // 6: asynchronous reset mid-lock clears everything at once
    chk("t6.pre_lock", 32'(locked), 1);
    #2 rst = 1'b1;
    #1;
    chk_all("t6.rst", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t6.rst_wrap", 32'(wrap_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    step(1, 0, 3'd5); chk_all("t6.s5", 2'b01, 1'b0, 1'b0, 1'b0, 3'd5);
    step(1, 0, 3'd6); chk("t6.s6", 32'(locked), 0);
    step(1, 0, 3'd7); chk("t6.s7", 32'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
